// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Holds the arbiter state encoding and the wrapping round-robin pointer step.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Next round-robin pointer, wrapping at nreq-1 -> 0 (nreq need not be a power of 2).
    function automatic int rr_next(input int ptr, input int nreq);
        return (ptr >= nreq - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first set req_valid bit searching rr_ptr, rr_ptr+1, ... with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the pick.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [IDW-1:0]  pick,
    output logic            any
);

    function automatic int wrap_idx(input int v);
        return (v >= NREQ) ? v - NREQ : v;
    endfunction

    always_comb begin
        pick = '0;
        any  = |req_valid;
        // Walk from farthest to nearest so the closest requester to rr_ptr wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[IDW'(wrap_idx(int'(rr_ptr) + k))]) begin
                pick = IDW'(wrap_idx(int'(rr_ptr) + k));
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ requesters, grant locked for <= BURST beats.
// Latency: 1-cycle arbitration per grant, then beats pass combinationally to wr/wdata.
// Backpressure: wfull deasserts the granted req_ready and wr; the grant is held through the stall.
module fifo_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int dw    = 2,
    parameter int BURST = 4
) (
    input  logic                      wclk,
    input  logic                      wrst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*dw-1:0]        req_data,
    input  logic [NREQ-1:0]           req_last,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      wfull,
    output logic                      wr,
    output logic [dw-1:0]             wdata,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy
);

    import fifo_arb_pkg::*;

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(BURST + 1);

    arb_state_e      state;
    logic [IDW-1:0]  rr_ptr;
    logic [CW-1:0]   beat_cnt;

    logic [IDW-1:0]  pick;
    logic            any;
    logic            g_valid;
    logic            g_last;
    logic [dw-1:0]   g_data;
    logic            done;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .pick      (pick),
        .any       (any)
    );

    assign busy = (state == GRANT);

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[i*dw +: dw];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = busy & ~wfull & (grant_id == IDW'(i));
        end
    end

    assign wr    = busy & g_valid & ~wfull;
    assign wdata = wr ? g_data : '0;

    // An idle granted requester releases even while the FIFO is full.
    assign done = busy & (~g_valid | (wr & (g_last | (beat_cnt == CW'(BURST - 1)))));

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            grant_id <= '0;
        end else if (state == IDLE) begin
            if (any) begin
                grant_id <= pick;
                rr_ptr   <= IDW'(rr_next(int'(pick), NREQ));
                beat_cnt <= '0;
                state    <= GRANT;
            end
        end else begin
            if (wr) begin
                beat_cnt <= beat_cnt + CW'(1);
            end
            if (done) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scenario bench for fifo_write_arbiter with a behavioural 16-entry FIFO and per-requester scoreboard.
module tb_fifo_write_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 2;
    localparam int BURST = 4;
    localparam int DEPTH = 16;

    logic                 wclk = 1'b0;
    logic                 wrst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      req_ready;
    logic                 wfull;
    logic                 wr;
    logic [DW-1:0]        wdata;
    logic [1:0]           grant_id;
    logic                 busy;

    fifo_write_arbiter #(
        .NREQ  (NREQ),
        .dw    (DW),
        .BURST (BURST)
    ) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wfull     (wfull),
        .wr        (wr),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 wclk = ~wclk;

    typedef struct packed {
        logic            busy;
        logic            wr;
        logic            wfull;
        logic [1:0]      gid;
        logic [DW-1:0]   wd;
        logic [NREQ-1:0] rdy;
    } snap_t;

    int n_tests;
    int n_fail;

    logic [DW-1:0] src_d [NREQ][$];
    logic          src_l [NREQ][$];
    logic [DW-1:0] exp_q [NREQ][$];
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] rd_log[$];
    snap_t         lg[$];
    logic [NREQ-1:0] src_en;
    logic          rd_en;
    bit            mon_en;

    // Scoreboard: every accepted beat must match the head of that requester's expected queue.
    logic [NREQ-1:0] m_acc;
    int              m_burst;
    bit              m_prev_busy;
    int              m_idx;

    always @(negedge wclk) begin
        if (mon_en) begin
            m_acc = req_ready & req_valid;
            if (wfull === 1'b1) begin
                n_tests++;
                if (wr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wr_while_full: wr=%b required 0", wr);
                end
            end
            if (busy === 1'b1 && !m_prev_busy) m_burst = 0;
            m_prev_busy = (busy === 1'b1);
            if (wr === 1'b1) begin
                m_burst++;
                n_tests++;
                if (m_burst > BURST) begin
                    n_fail++;
                    $display("FAIL burst_cap: beats=%0d required <=%0d", m_burst, BURST);
                end
                n_tests++;
                if ($countones(m_acc) != 1) begin
                    n_fail++;
                    $display("FAIL accept_onehot: accepted=%b required one bit", m_acc);
                end else begin
                    m_idx = 0;
                    for (int k = 0; k < NREQ; k++) if (m_acc[k]) m_idx = k;
                    if (exp_q[m_idx].size() == 0) begin
                        n_fail++;
                        $display("FAIL beat_dup: req %0d wrote %b with nothing pending", m_idx, wdata);
                    end else begin
                        if (wdata !== exp_q[m_idx][0]) begin
                            n_fail++;
                            $display("FAIL beat_order: req %0d wdata=%b required %b", m_idx, wdata, exp_q[m_idx][0]);
                        end
                        void'(exp_q[m_idx].pop_front());
                    end
                end
            end else if (m_acc != '0) begin
                n_tests++;
                n_fail++;
                $display("FAIL beat_lost: accepted=%b with wr=%b required wr=1", m_acc, wr);
            end
        end
    end

    task automatic add_beat(input int i, input logic [DW-1:0] d, input logic l);
        src_d[i].push_back(d);
        src_l[i].push_back(l);
        exp_q[i].push_back(d);
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (src_en[i] && src_d[i].size() > 0) begin
                req_valid[i]         = 1'b1;
                req_data[i*DW +: DW] = src_d[i][0];
                req_last[i]          = src_l[i][0];
            end else begin
                req_valid[i]         = 1'b0;
                req_data[i*DW +: DW] = '0;
                req_last[i]          = 1'b0;
            end
        end
        wfull = (fifo_q.size() >= DEPTH);
    endtask

    task automatic tick();
        snap_t           s;
        logic [NREQ-1:0] acc;
        logic            do_wr;
        logic [DW-1:0]   wd;
        drive();
        @(negedge wclk);
        #1;
        s.busy = busy; s.wr = wr; s.wfull = wfull; s.gid = grant_id; s.wd = wdata; s.rdy = req_ready;
        lg.push_back(s);
        acc   = req_ready & req_valid;
        do_wr = wr;
        wd    = wdata;
        @(posedge wclk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i] === 1'b1 && src_d[i].size() > 0) begin
                void'(src_d[i].pop_front());
                void'(src_l[i].pop_front());
            end
        end
        if (rd_en && fifo_q.size() > 0) rd_log.push_back(fifo_q.pop_front());
        if (do_wr === 1'b1) fifo_q.push_back(wd);
        drive();
    endtask

    task automatic env_reset();
        src_en = '0;
        rd_en  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            src_d[i].delete();
            src_l[i].delete();
            exp_q[i].delete();
        end
        fifo_q.delete();
        rd_log.delete();
        wrst = 1'b1;
        tick();
        wrst = 1'b0;
        lg.delete();
    endtask

    task automatic test_reset();
        env_reset();
        for (int i = 0; i < NREQ; i++) begin
            add_beat(i, DW'(i), 1'b0);
            add_beat(i, DW'(i + 1), 1'b1);
        end
        src_en = 4'b1111;
        wrst = 1'b1;
        tick();
        tick();
        n_tests++; if (lg[1].busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", lg[1].busy); end
        n_tests++; if (lg[1].wr !== 1'b0) begin n_fail++; $display("FAIL rst_wr: got %b want 0", lg[1].wr); end
        n_tests++; if (lg[1].wd !== 2'b00) begin n_fail++; $display("FAIL rst_wdata: got %b want 00", lg[1].wd); end
        n_tests++; if (lg[1].rdy !== 4'b0000) begin n_fail++; $display("FAIL rst_ready: got %b want 0000", lg[1].rdy); end
        n_tests++; if (lg[1].gid !== 2'd0) begin n_fail++; $display("FAIL rst_grant_id: got %0d want 0", lg[1].gid); end
        wrst = 1'b0;
        tick();
        tick();
        n_tests++; if (lg[2].busy !== 1'b0) begin n_fail++; $display("FAIL rst_arb_bubble: busy=%b want 0", lg[2].busy); end
        n_tests++; if (lg[3].busy !== 1'b1 || lg[3].gid !== 2'd0) begin
            n_fail++; $display("FAIL rst_first_grant: busy=%b gid=%0d want busy=1 gid=0", lg[3].busy, lg[3].gid);
        end
    endtask

    task automatic test_single_packet();
        logic [DW-1:0] want [3];
        want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b11;
        env_reset();
        add_beat(1, want[0], 1'b0);
        add_beat(1, want[1], 1'b0);
        add_beat(1, want[2], 1'b1);
        src_en = 4'b0010;
        repeat (6) tick();
        n_tests++; if (lg[0].busy !== 1'b0 || lg[0].wr !== 1'b0) begin
            n_fail++; $display("FAIL pkt_arb_cycle: busy=%b wr=%b want 0 0", lg[0].busy, lg[0].wr);
        end
        n_tests++; if (lg[1].gid !== 2'd1 || lg[1].busy !== 1'b1) begin
            n_fail++; $display("FAIL pkt_grant_id: gid=%0d busy=%b want 1 1", lg[1].gid, lg[1].busy);
        end
        for (int j = 0; j < 3; j++) begin
            n_tests++;
            if (lg[j+1].wr !== 1'b1 || lg[j+1].wd !== want[j]) begin
                n_fail++; $display("FAIL pkt_beat%0d: wr=%b wdata=%b want 1 %b", j, lg[j+1].wr, lg[j+1].wd, want[j]);
            end
        end
        n_tests++; if (lg[4].busy !== 1'b0 || lg[4].wr !== 1'b0) begin
            n_fail++; $display("FAIL pkt_release: busy=%b wr=%b want 0 0", lg[4].busy, lg[4].wr);
        end
        rd_en = 1'b1;
        repeat (4) tick();
        n_tests++;
        if (rd_log.size() != 3) begin
            n_fail++; $display("FAIL pkt_fifo_count: got %0d want 3", rd_log.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                n_tests++;
                if (rd_log[j] !== want[j]) begin
                    n_fail++; $display("FAIL pkt_rdata%0d: got %b want %b", j, rd_log[j], want[j]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int cnt;
        env_reset();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 10; k++) add_beat(i, DW'(k + i), 1'b0);
        src_en = 4'b1111;
        rd_en  = 1'b1;
        repeat (26) tick();
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (lg[5*k].busy !== 1'b0) begin
                n_fail++; $display("FAIL rr_bubble%0d: busy=%b want 0", k, lg[5*k].busy);
            end
            n_tests++;
            if (lg[5*k+1].gid !== 2'(k % NREQ)) begin
                n_fail++; $display("FAIL rr_order%0d: gid=%0d want %0d", k, lg[5*k+1].gid, k % NREQ);
            end
            cnt = 0;
            for (int j = 1; j <= 4; j++)
                if (lg[5*k+j].busy === 1'b1 && lg[5*k+j].wr === 1'b1 && lg[5*k+j].gid === 2'(k % NREQ)) cnt++;
            n_tests++;
            if (cnt != 4) begin
                n_fail++; $display("FAIL rr_burst%0d: beats=%0d want 4", k, cnt);
            end
        end
        n_tests++; if (lg[25].busy !== 1'b0) begin n_fail++; $display("FAIL rr_cap_release: busy=%b want 0", lg[25].busy); end
    endtask

    task automatic test_full_stall();
        int guard;
        int viol;
        int fullc;
        int wrs;
        env_reset();
        for (int k = 0; k < 24; k++) add_beat(2, DW'(k * 3), 1'b0);
        src_en = 4'b0100;
        guard = 0;
        while (fifo_q.size() < DEPTH && guard < 100) begin tick(); guard++; end
        n_tests++; if (fifo_q.size() != DEPTH) begin n_fail++; $display("FAIL full_fill: size=%0d want %0d", fifo_q.size(), DEPTH); end
        lg.delete();
        repeat (8) tick();
        viol = 0; fullc = 0;
        foreach (lg[j]) begin
            if (lg[j].wfull === 1'b1) begin
                fullc++;
                if (lg[j].wr !== 1'b0 || lg[j].rdy[2] !== 1'b0) viol++;
            end
        end
        n_tests++; if (fullc != 8) begin n_fail++; $display("FAIL full_hold: full cycles=%0d want 8", fullc); end
        n_tests++; if (viol != 0) begin n_fail++; $display("FAIL full_stall: violating cycles=%0d want 0", viol); end
        for (int r = 0; r < 3; r++) begin
            lg.delete();
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            repeat (5) tick();
            wrs = 0;
            foreach (lg[j]) if (lg[j].wr === 1'b1) wrs++;
            n_tests++; if (wrs != 1) begin n_fail++; $display("FAIL full_one_slot%0d: writes=%0d want 1", r, wrs); end
        end
        rd_en = 1'b1;
        guard = 0;
        while ((exp_q[2].size() > 0 || fifo_q.size() > 0) && guard < 200) begin tick(); guard++; end
        n_tests++; if (exp_q[2].size() != 0) begin n_fail++; $display("FAIL full_drain: pending=%0d want 0", exp_q[2].size()); end
        n_tests++;
        if (rd_log.size() != 24) begin
            n_fail++; $display("FAIL full_total: read=%0d want 24", rd_log.size());
        end else begin
            viol = 0;
            for (int k = 0; k < 24; k++) if (rd_log[k] !== DW'(k * 3)) viol++;
            n_tests++; if (viol != 0) begin n_fail++; $display("FAIL full_data: wrong entries=%0d want 0", viol); end
        end
    endtask

    task automatic test_valid_drop_wrap();
        env_reset();
        add_beat(2, 2'b10, 1'b1);
        add_beat(3, 2'b01, 1'b0);
        add_beat(0, 2'b11, 1'b0);
        add_beat(0, 2'b00, 1'b1);
        add_beat(1, 2'b01, 1'b1);
        src_en = 4'b1100;
        rd_en  = 1'b1;
        repeat (5) tick();
        src_en = 4'b1111;
        repeat (2) tick();
        n_tests++; if (lg[1].gid !== 2'd2 || lg[1].wr !== 1'b1) begin n_fail++; $display("FAIL drop_first: gid=%0d wr=%b want 2 1", lg[1].gid, lg[1].wr); end
        n_tests++; if (lg[3].gid !== 2'd3 || lg[3].wr !== 1'b1) begin n_fail++; $display("FAIL drop_grant3: gid=%0d wr=%b want 3 1", lg[3].gid, lg[3].wr); end
        n_tests++; if (lg[4].busy !== 1'b1 || lg[4].wr !== 1'b0) begin n_fail++; $display("FAIL drop_idle_cycle: busy=%b wr=%b want 1 0", lg[4].busy, lg[4].wr); end
        n_tests++; if (lg[5].busy !== 1'b0) begin n_fail++; $display("FAIL drop_release: busy=%b want 0", lg[5].busy); end
        n_tests++; if (lg[6].busy !== 1'b1 || lg[6].gid !== 2'd0) begin n_fail++; $display("FAIL drop_wrap: busy=%b gid=%0d want 1 0", lg[6].busy, lg[6].gid); end
    endtask

    task automatic test_reset_mid_burst();
        env_reset();
        for (int k = 0; k < 6; k++) add_beat(1, DW'(k), 1'b0);
        for (int k = 0; k < 3; k++) begin
            add_beat(0, DW'(k + 1), 1'b0);
            add_beat(2, DW'(k + 2), 1'b0);
            add_beat(3, DW'(k + 3), 1'b0);
        end
        src_en = 4'b0010;
        rd_en  = 1'b1;
        tick();
        tick();
        wrst = 1'b1;
        tick();
        wrst = 1'b0;
        src_en = 4'b1111;
        tick();
        tick();
        n_tests++; if (lg[2].wr !== 1'b1 || lg[2].gid !== 2'd1) begin n_fail++; $display("FAIL mid_beat2: wr=%b gid=%0d want 1 1", lg[2].wr, lg[2].gid); end
        n_tests++; if (lg[3].busy !== 1'b0 || lg[3].wr !== 1'b0 || lg[3].gid !== 2'd0 || lg[3].rdy !== 4'b0000) begin
            n_fail++; $display("FAIL mid_abandon: busy=%b wr=%b gid=%0d rdy=%b want 0 0 0 0000", lg[3].busy, lg[3].wr, lg[3].gid, lg[3].rdy);
        end
        n_tests++; if (lg[4].busy !== 1'b1 || lg[4].gid !== 2'd0) begin n_fail++; $display("FAIL mid_regrant: busy=%b gid=%0d want 1 0", lg[4].busy, lg[4].gid); end
    endtask

    task automatic test_random();
        int guard;
        bit pending;
        env_reset();
        repeat (1000) begin
            for (int i = 0; i < NREQ; i++) begin
                if (src_d[i].size() < 3 && $urandom_range(0, 1) == 1)
                    add_beat(i, DW'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
                src_en[i] = ($urandom_range(0, 4) != 0);
            end
            rd_en = ($urandom_range(0, 9) < 4);
            tick();
        end
        src_en = 4'b1111;
        rd_en  = 1'b1;
        guard  = 0;
        pending = 1'b1;
        while (pending && guard < 400) begin
            tick();
            guard++;
            pending = 1'b0;
            for (int i = 0; i < NREQ; i++) if (src_d[i].size() > 0) pending = 1'b1;
        end
        for (int i = 0; i < NREQ; i++) begin
            n_tests++;
            if (exp_q[i].size() != 0) begin
                n_fail++; $display("FAIL rand_drain%0d: pending=%0d want 0", i, exp_q[i].size());
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mon_en  = 1'b0;
        m_burst = 0;
        m_prev_busy = 1'b0;
        src_en  = '0;
        rd_en   = 1'b0;
        wrst    = 1'b1;
        drive();
        tick();
        tick();
        mon_en = 1'b1;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_full_stall();
        test_valid_drop_wrap();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
